asteroid_field: RTL and testbench
=================================

Name: asteroid_field

Overview:
Multi-slot successor to the single asteroid sprite. Owns SLOTS independent asteroid slots, spawns them from an internal LFSR, moves them once per frame, resolves player shots against them, and produces the per-pixel drawing/colour stream for the compositor. It sits between the frame/line timing generator and the pixel mixer.

Parameters:
SLOTS, 8, number of asteroid slots (1..16)
SIZE, 16, asteroid square edge in pixels
H_RES, 640, horizontal active resolution
V_RES, 480, vertical active resolution
CORDW, 16, signed screen coordinate width
COLR_BITS, 4, pixel colour width
SPAWN_INTERVAL, 32, frames between spawn attempts (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
frame  in  1  one-cycle pulse at start of vertical blank
speed  in  4  pixels moved per frame by every active asteroid
shot_valid  in  1  one-cycle shot test request
shot_x  in  CORDW  signed shot x
shot_y  in  CORDW  signed shot y
shot_hit  out  1  one-cycle pulse: last shot destroyed an asteroid
escaped  out  1  one-cycle pulse: an asteroid left the bottom edge
overrun  out  1  one-cycle pulse: frame arrived while update busy
active_count  out  $clog2(SLOTS+1)  number of active slots
screen_x  in  CORDW  signed current beam x
screen_y  in  CORDW  signed current beam y
drawing  out  1  beam inside an active asteroid
pixel  out  COLR_BITS  colour of drawn asteroid, 0 when not drawing

Behaviour:
- Reset (rst low, async): all slots inactive, x=y=0, colour=0; LFSR=LFSR_SEED; frame counter=0; FSM=IDLE; all outputs 0.
- LFSR: 16-bit Galois, mask 16'hB400, advances every clk outside reset; never reaches 0.
- Per-slot state: active, x (unsigned, 0..H_RES-SIZE-1), y (signed CORDW), colour.
- FSM: IDLE -> UPDATE on frame. UPDATE visits slot 0..SLOTS-1, one per cycle: if active, y <= y + speed (zero-extended); if new y >= V_RES, slot cleared and escaped pulses that cycle. After last slot -> SPAWN (one cycle) -> IDLE. Total busy = SLOTS+1 cycles after frame.
- Frame counter increments on each accepted frame, wraps at SPAWN_INTERVAL. In SPAWN, if counter == 0 and a free slot exists, lowest-index free slot: active=1, x = lfsr[CORDW-2:0] mod (H_RES-SIZE), y = -SIZE, colour = lfsr[COLR_BITS-1:0], forced to 1 if zero. No free slot: attempt dropped silently.
- frame while not IDLE: ignored, overrun pulses next cycle, counter unchanged.
- Shot: on shot_valid, hit if any active slot has x <= shot_x < x+SIZE and y <= shot_y < y+SIZE (signed compare). Lowest-index hit slot cleared; shot_hit pulses the cycle after shot_valid. At most one slot cleared per shot.
- Shot vs UPDATE same cycle on same slot: clear wins, no move, no escaped. Shot vs SPAWN into same slot same cycle: spawn wins (shot tested against prior state, slot was free).
- Drawing: containment test of screen_x/screen_y against all active slots; drawing/pixel registered, 1-cycle latency. Overlap: lowest-index slot's colour.
- active_count registered, reflects slot state the cycle after any change.
- Arithmetic: y addition in CORDW+1 bits before compare, no wrap. speed=0 freezes motion; spawning continues.

Test Plan:
- Reset: hold rst=0 then release; drawing=0, pixel=0, active_count=0, shot_hit=0; LFSR matches model from 16'hACE1.
- Spawn: SPAWN_INTERVAL=2, SLOTS=4, 2 frame pulses -> slot 0 active, y=-16, x = model LFSR mod 624, active_count=1 at SPAWN+1.
- Motion/escape: speed=4, one asteroid at y=-16; after 124 frames y=480 -> escaped pulses once, active_count decrements.
- Shot: asteroid x=100,y=50; shot (107,57) -> shot_hit one cycle later, slot cleared; shot (116,57) -> no hit.
- Full/overrun: SLOTS=2 full, further spawn dropped, count stays 2; frame pulse 3 cycles after previous frame -> overrun=1, no double move.
- Drawing: asteroid colour 5 at (200,100); beam (200,100) -> drawing=1,pixel=5 next cycle; beam (216,100) -> drawing=0,pixel=0; async reset mid-UPDATE clears all slots immediately.

Source files
------------

// File: rtl/asteroid_field.sv
`default_nettype none
// ============================================================================
//  Module      : asteroid_field
//  Description : Multi-slot asteroid field. Spawns asteroids from an internal
//                LFSR, moves every active slot once per frame, resolves player
//                shots against them and produces a registered per-pixel
//                drawing/colour stream for the compositor.
//  Revision    : 1.0  initial release
// ============================================================================
module asteroid_field #(
    parameter int          SLOTS          = 8,
    parameter int          SIZE           = 16,
    parameter int          H_RES          = 640,
    parameter int          V_RES          = 480,
    parameter int          CORDW          = 16,
    parameter int          COLR_BITS      = 4,
    parameter int          SPAWN_INTERVAL = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame,
    input  logic [3:0]                   speed,
    input  logic                         shot_valid,
    input  logic [CORDW-1:0]             shot_x,
    input  logic [CORDW-1:0]             shot_y,
    output logic                         shot_hit,
    output logic                         escaped,
    output logic                         overrun,
    output logic [$clog2(SLOTS+1)-1:0]   active_count,
    input  logic [CORDW-1:0]             screen_x,
    input  logic [CORDW-1:0]             screen_y,
    output logic                         drawing,
    output logic [COLR_BITS-1:0]         pixel
);

    localparam int c_idx_w = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int c_cnt_w = $clog2(SLOTS + 1);
    localparam int c_fc_w  = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    localparam logic signed [CORDW:0]   c_size      = (CORDW+1)'(SIZE);
    localparam logic signed [CORDW:0]   c_vres      = (CORDW+1)'(V_RES);
    localparam logic [CORDW-1:0]        c_xrange    = CORDW'(H_RES - SIZE);
    localparam logic signed [CORDW-1:0] c_spawn_y   = CORDW'(-SIZE);
    localparam logic [15:0]             c_lfsr_mask = 16'hB400;
    localparam logic [c_idx_w-1:0]      c_last_idx  = c_idx_w'(SLOTS - 1);
    localparam logic [c_fc_w-1:0]       c_last_fc   = c_fc_w'(SPAWN_INTERVAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_SPAWN  = 2'd2
    } state_t;

    state_t                    r_state, w_state_next;
    logic [c_idx_w-1:0]        r_idx, w_idx_next;
    logic [15:0]               r_lfsr;
    logic [15:0]               w_lfsr_next;
    logic [c_fc_w-1:0]         r_fcount;

    // Slot storage
    logic [SLOTS-1:0]          r_active;
    logic [CORDW-1:0]          r_x      [SLOTS];
    logic signed [CORDW-1:0]   r_y      [SLOTS];
    logic [COLR_BITS-1:0]      r_colour [SLOTS];

    // Registered outputs
    logic                      r_shot_hit;
    logic                      r_escaped;
    logic                      r_overrun;
    logic [c_cnt_w-1:0]        r_active_count;
    logic                      r_drawing;
    logic [COLR_BITS-1:0]      r_pixel;

    // Slot scan results
    logic [SLOTS-1:0]          w_shot_sel;
    logic                      w_shot_any;
    logic [SLOTS-1:0]          w_free_sel;
    logic                      w_free_any;
    logic [SLOTS-1:0]          w_esc;
    logic                      w_draw_any;
    logic [COLR_BITS-1:0]      w_draw_col;
    logic [c_cnt_w-1:0]        w_count;
    logic signed [CORDW:0]     w_y_new  [SLOTS];

    logic                      w_do_spawn;
    logic [CORDW-1:0]          w_spawn_x;
    logic [COLR_BITS-1:0]      w_spawn_col;

    // Square containment in CORDW+1 signed bits so x+SIZE / y+SIZE never wrap
    function automatic logic f_inside(input logic [CORDW-1:0]        ax,
                                      input logic signed [CORDW-1:0] ay,
                                      input logic [CORDW-1:0]        px,
                                      input logic [CORDW-1:0]        py);
        logic signed [CORDW:0] lx, ly, qx, qy;
        lx = $signed({1'b0, ax});
        ly = $signed({ay[CORDW-1], ay});
        qx = $signed({px[CORDW-1], px});
        qy = $signed({py[CORDW-1], py});
        return (qx >= lx) && (qx < lx + c_size) && (qy >= ly) && (qy < ly + c_size);
    endfunction

    // Scan all slots: shot target, free slot, beam hit, motion and population
    always_comb begin
        w_shot_sel = '0;
        w_shot_any = 1'b0;
        w_free_sel = '0;
        w_free_any = 1'b0;
        w_esc      = '0;
        w_draw_any = 1'b0;
        w_draw_col = '0;
        w_count    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            w_y_new[i] = $signed({r_y[i][CORDW-1], r_y[i]})
                       + $signed({{(CORDW-3){1'b0}}, speed});
            if (shot_valid && r_active[i] && !w_shot_any &&
                f_inside(r_x[i], r_y[i], shot_x, shot_y)) begin
                w_shot_sel[i] = 1'b1;
                w_shot_any    = 1'b1;
            end
            if (r_active[i] && !w_draw_any &&
                f_inside(r_x[i], r_y[i], screen_x, screen_y)) begin
                w_draw_any = 1'b1;
                w_draw_col = r_colour[i];
            end
            if (!r_active[i] && !w_free_any) begin
                w_free_sel[i] = 1'b1;
                w_free_any    = 1'b1;
            end
            // A slot destroyed by a shot in its update cycle neither moves nor escapes
            w_esc[i] = (r_state == ST_UPDATE) && (r_idx == c_idx_w'(i)) && r_active[i] &&
                       !w_shot_sel[i] && (w_y_new[i] >= c_vres);
            w_count = w_count + c_cnt_w'(r_active[i]);
        end
    end

    // Spawn parameters derived from the current LFSR state
    always_comb begin
        w_do_spawn  = (r_state == ST_SPAWN) && (r_fcount == '0) && w_free_any;
        w_spawn_x   = {1'b0, r_lfsr[CORDW-2:0]} % c_xrange;
        w_spawn_col = (r_lfsr[COLR_BITS-1:0] == '0) ? COLR_BITS'(1) : r_lfsr[COLR_BITS-1:0];
        w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);
    end

    // Next-state logic: frame starts a walk over every slot, then one spawn cycle
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (frame) begin
                    w_state_next = ST_UPDATE;
                    w_idx_next   = '0;
                end
            end
            ST_UPDATE: begin
                if (r_idx == c_last_idx) begin
                    w_state_next = ST_SPAWN;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            ST_SPAWN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // State register, LFSR and frame counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_lfsr   <= LFSR_SEED;
            r_fcount <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_lfsr  <= w_lfsr_next;
            if (frame && (r_state == ST_IDLE)) begin
                r_fcount <= (r_fcount == c_last_fc) ? '0 : r_fcount + 1'b1;
            end
        end
    end

    // Slot state: spawn beats shot-clear, shot-clear beats motion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_x[i]      <= '0;
                r_y[i]      <= '0;
                r_colour[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (w_do_spawn && w_free_sel[i]) begin
                    r_active[i] <= 1'b1;
                    r_x[i]      <= w_spawn_x;
                    r_y[i]      <= c_spawn_y;
                    r_colour[i] <= w_spawn_col;
                end else if (w_shot_sel[i]) begin
                    r_active[i] <= 1'b0;
                end else if (w_esc[i]) begin
                    r_active[i] <= 1'b0;
                end else if ((r_state == ST_UPDATE) && (r_idx == c_idx_w'(i)) && r_active[i]) begin
                    r_y[i] <= w_y_new[i][CORDW-1:0];
                end
            end
        end
    end

    // Registered event pulses, population count and pixel stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shot_hit     <= 1'b0;
            r_escaped      <= 1'b0;
            r_overrun      <= 1'b0;
            r_active_count <= '0;
            r_drawing      <= 1'b0;
            r_pixel        <= '0;
        end else begin
            r_shot_hit     <= w_shot_any;
            r_escaped      <= |w_esc;
            r_overrun      <= frame && (r_state != ST_IDLE);
            r_active_count <= w_count;
            r_drawing      <= w_draw_any;
            r_pixel        <= w_draw_col;
        end
    end

    assign shot_hit     = r_shot_hit;
    assign escaped      = r_escaped;
    assign overrun      = r_overrun;
    assign active_count = r_active_count;
    assign drawing      = r_drawing;
    assign pixel        = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_asteroid_field.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asteroid_field
//  Description : Randomized scoreboard bench for asteroid_field with a
//                frame-level reference model of the asteroid slots.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_asteroid_field;

    localparam int SLOTS = 4;
    localparam int SIZE  = 16;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int CORDW = 16;
    localparam int CB    = 4;
    localparam int SI    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame = 1'b0;
    logic [3:0]        speed = 4'd0;
    logic              shot_valid = 1'b0;
    logic [CORDW-1:0]  shot_x = '0;
    logic [CORDW-1:0]  shot_y = '0;
    logic [CORDW-1:0]  screen_x = '0;
    logic [CORDW-1:0]  screen_y = '0;
    logic              shot_hit, escaped, overrun, drawing;
    logic [2:0]        active_count;
    logic [CB-1:0]     pixel;

    asteroid_field #(
        .SLOTS(SLOTS), .SIZE(SIZE), .H_RES(H_RES), .V_RES(V_RES), .CORDW(CORDW),
        .COLR_BITS(CB), .SPAWN_INTERVAL(SI), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .speed(speed),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .shot_hit(shot_hit), .escaped(escaped), .overrun(overrun),
        .active_count(active_count), .screen_x(screen_x), .screen_y(screen_y),
        .drawing(drawing), .pixel(pixel)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_act [SLOTS];
    int          m_x   [SLOTS];
    int          m_y   [SLOTS];
    int          m_col [SLOTS];
    int          m_fc;
    logic [15:0] m_lfsr;

    // The LFSR free-runs from the seed every clock outside reset
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic bit inside_sq(input int ax, input int ay, input int px, input int py);
        return (px >= ax) && (px < ax + SIZE) && (py >= ay) && (py < ay + SIZE);
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) n += m_act[i];
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_col[i] = 0;
        end
        m_fc = 0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { int d; int p; int c; } beam_t;
    int    hit_q [$];
    int    esc_q [$];
    int    ovr_q [$];
    beam_t beam_q [$];
    logic  beam_chk = 1'b0;
    logic  d_shot = 1'b0;
    logic  d_beam = 1'b0;

    always @(posedge clk) begin
        d_shot <= shot_valid;
        d_beam <= beam_chk;
    end

    // Monitor: compares DUT responses against queued expectations
    always @(negedge clk) begin
        if (rst) begin
            if (d_shot) begin
                chk("shot_expected", int'(hit_q.size() > 0), 1);
                if (hit_q.size() > 0) chk("shot_hit", shot_hit, hit_q.pop_front());
            end else if (shot_hit) begin
                chk("spurious_shot_hit", shot_hit, 0);
            end
            if (escaped) begin
                chk("escape_expected", int'(esc_q.size() > 0), 1);
                if (esc_q.size() > 0) void'(esc_q.pop_front());
            end
            if (overrun) begin
                chk("overrun_expected", int'(ovr_q.size() > 0), 1);
                if (ovr_q.size() > 0) void'(ovr_q.pop_front());
            end
            if (d_beam) begin
                chk("beam_expected", int'(beam_q.size() > 0), 1);
                if (beam_q.size() > 0) begin
                    beam_t b;
                    b = beam_q.pop_front();
                    chk("drawing", drawing, b.d);
                    chk("pixel", pixel, b.p);
                    chk("active_count", active_count, b.c);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame(input bit ovr);
        logic [15:0] sl;
        // motion and escapes over the whole field
        for (int i = 0; i < SLOTS; i++) begin
            if (m_act[i] != 0) begin
                m_y[i] = m_y[i] + int'(speed);
                if (m_y[i] >= V_RES) begin
                    m_act[i] = 0;
                    esc_q.push_back(1);
                end
            end
        end
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
        tick(2);
        if (ovr) begin
            frame = 1'b1;
            ovr_q.push_back(1);
        end
        tick(1);
        frame = 1'b0;
        tick(1);
        sl = m_lfsr;        // LFSR state seen by the spawn cycle
        m_fc = (m_fc + 1) % SI;
        if (m_fc == 0) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (m_act[i] == 0) begin
                    m_act[i] = 1;
                    m_x[i]   = int'(sl & 16'h7FFF) % (H_RES - SIZE);
                    m_y[i]   = -SIZE;
                    m_col[i] = (int'(sl & 16'h000F) == 0) ? 1 : int'(sl & 16'h000F);
                    break;
                end
            end
        end
        tick(2);
        chk("escape_drain", esc_q.size(), 0);
        chk("overrun_drain", ovr_q.size(), 0);
    endtask

    task automatic do_shot(input int px, input int py);
        int hit = 0;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_act[i] != 0 && inside_sq(m_x[i], m_y[i], px, py)) begin
                m_act[i] = 0;
                hit = 1;
                break;
            end
        end
        hit_q.push_back(hit);
        shot_x = 16'(px);
        shot_y = 16'(py);
        shot_valid = 1'b1;
        tick(1);
        shot_valid = 1'b0;
        tick(2);
    endtask

    task automatic do_beam(input int px, input int py);
        beam_t b;
        b.d = 0; b.p = 0; b.c = model_count();
        for (int i = 0; i < SLOTS; i++) begin
            if (m_act[i] != 0 && inside_sq(m_x[i], m_y[i], px, py)) begin
                b.d = 1; b.p = m_col[i];
                break;
            end
        end
        beam_q.push_back(b);
        screen_x = 16'(px);
        screen_y = 16'(py);
        beam_chk = 1'b1;
        tick(1);
        beam_chk = 1'b0;
    endtask

    // Pick a point near a random live asteroid (edges included) or anywhere
    task automatic rand_point(output int px, output int py);
        int s;
        s = $urandom_range(0, SLOTS - 1);
        if (m_act[s] != 0 && $urandom_range(0, 3) != 0) begin
            px = m_x[s] + $urandom_range(0, SIZE + 3) - 2;
            py = m_y[s] + $urandom_range(0, SIZE + 3) - 2;
        end else begin
            px = $urandom_range(0, H_RES - 1);
            py = $urandom_range(0, 511) - 24;
        end
    endtask

    initial begin
        int px, py, sx;
        model_reset();
        tick(3);
        chk("rst_drawing", drawing, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_active_count", active_count, 0);
        chk("rst_shot_hit", shot_hit, 0);
        chk("rst_escaped", escaped, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        tick(2);
        do_beam(0, 0);

        // First spawn on the second frame
        speed = 4'd0;
        do_frame(1'b0);
        do_frame(1'b0);
        do_beam(m_x[0], -SIZE);
        do_beam(m_x[0] + SIZE, -SIZE);
        do_beam(m_x[0] + SIZE - 1, -1);

        for (int it = 0; it < 160; it++) begin
            speed = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            do_frame($urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) begin
                rand_point(px, py);
                do_shot(px, py);
            end
            repeat ($urandom_range(1, 3)) begin
                rand_point(px, py);
                do_beam(px, py);
            end
            tick($urandom_range(0, 6));
        end

        // Asynchronous reset in the middle of an update walk
        speed = 4'd0;
        do_frame(1'b0);
        do_frame(1'b0);
        sx = m_x[0];
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
        tick(1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_active_count", active_count, 0);
        chk("async_rst_drawing", drawing, 0);
        chk("async_rst_pixel", pixel, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        do_beam(sx, m_y[0]);
        do_frame(1'b0);
        do_frame(1'b0);
        do_beam(m_x[0] + 3, -SIZE + 5);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
